melody_player: RTL
==================

# melody_player

Table-driven buzzer melody engine for the 48 MHz sys_clk domain. It replaces hard-coded note/beat case lists with a song stored in an external synchronous ROM: one entry per note, each with a pitch code and a duration in beats. Adds start/stop/pause control, looping, a per-note articulation gap and completion status. It drives the board buzzer directly through a square-wave tone generator.

## Interface
- CLK_HZ, 48_000_000: sys_clk frequency; documentation only, the pitch table is computed for this value.
- BEAT_CYCLES, 12_000_000: cycles per beat (250 ms).
- GAP_CYCLES, 480_000: silent cycles at the end of every note (10 ms); 0 disables; must be < BEAT_CYCLES.
- ROM_AW, 8: song ROM address width (up to 256 entries).
- sys_clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low; single clock domain.
- start  in  1  pulse; starts the song from address 0 when idle.
- stop  in  1  pulse; aborts playback.
- pause  in  1  level; freezes playback while high.
- loop_en  in  1  level; sampled at the end marker.
- rom_addr  out  ROM_AW  song ROM address.
- rom_data  in  8  ROM entry; valid 1 cycle after rom_addr changes. Bits [7:4] are the pitch code, bits [3:0] the duration in beats.
- beep  out  1  buzzer drive.
- busy  out  1  high from the start acceptance edge until return to IDLE.
- done  out  1  one-cycle pulse on normal (non-loop) completion.
- note_idx  out  ROM_AW  address of the entry currently playing.

## Operation
- Pitch codes give half-periods in cycles:
  - 0 = rest
  - 1 = L_5 61224, 2 = L_6 54545, 3 = M_1 45863, 4 = M_2 40865
  - 5 = M_3 36402, 6 = M_5 30612, 7 = M_6 27273, 8 = H_1 22956
  - 9–15 are reserved and play as rest.
- Duration 0 is the end marker (pitch ignored).
- FSM states: IDLE, FETCH, DECODE, PLAY, GAP.
- IDLE: when start=1, go to FETCH with rom_addr=0.
- FETCH: one cycle; the ROM access is in flight.
- DECODE:
  - If dur≠0: latch pitch, load note_cnt = dur*BEAT_CYCLES − GAP_CYCLES, clear the tone counter and beep, go to PLAY.
  - If dur=0 and loop_en=1: rom_addr=0, go to FETCH.
  - If dur=0 and loop_en=0: done=1, go to IDLE.
- PLAY: note_cnt counts down, then go to GAP (or straight to FETCH if GAP_CYCLES=0) with beep=0.
- GAP: count GAP_CYCLES, then rom_addr+1 and go to FETCH. rom_addr wraps from 2^ROM_AW−1 to 0 with no end implied.
- Tone generator:
  - Counts 0..hp−1 and toggles beep at hp−1, so the period is 2·hp.
  - For a rest, beep is held 0 and the counter is idle.
- Width rule: note_cnt is wide enough for 15*BEAT_CYCLES (28 bits at default), with no truncation.
- Boundary rules:
  - stop has priority over start in the same cycle. stop in any state forces IDLE next edge with beep=0, busy=0, no done.
  - start while busy is ignored.
  - pause=1 freezes note_cnt, gap counter, tone counter and FSM; beep reads 0 while paused. On release, playback resumes from the frozen counts with beep=0.
  - pause in IDLE has no effect. pause does not block stop.
  - Reset mid-song returns to IDLE immediately with all outputs 0.
- Reset values: beep=0, busy=0, done=0, rom_addr=0, note_idx=0, state IDLE.

## Timing
- start sampled at edge E0: busy=1 and state FETCH after E0. DECODE after E0+1. PLAY entered at E0+2.
- First beep rise at E0+2+hp.
- Each note occupies exactly dur*BEAT_CYCLES cycles (PLAY+GAP) plus 2 silent fetch cycles.
- done asserts for the cycle after the DECODE of the end marker; busy falls on the same edge.
- note_idx updates on the DECODE→PLAY edge.
- All outputs are registered.

## Structure
- Shared package melody_pkg holds:
  - the pitch-code enum
  - the half-period constant array (16×16-bit, reserved entries 0)
  - the FSM state typedef
  - the entry field positions
- One sub-module, tone_gen: inputs clk, rst_n, en, clear, hp[15:0]; output beep. It contains the half-period counter and toggle.
- The ROM stays external and song-specific.

## Test plan
Bench parameters: BEAT_CYCLES=200_000, GAP_CYCLES=1_000.
- ROM {0x31, 0x00}; start → busy=1 next cycle; beep rises at start+2+45863 with period 91726; beep=0 for the final 1000 cycles; one done pulse; busy=0.
- ROM {0x02, 0x51, 0x00} → beep stays 0 for 400_000 cycles, then M_3 tone (period 72804) for 200_000 cycles; note_idx goes 0,1.
- loop_en=1, ROM {0x11, 0x00} → rom_addr sequence 0,1,0,1…; no done; busy stays 1. Drop loop_en → done pulse after the next end marker.
- pause high for 5_000 cycles mid-note → beep=0 throughout; the note ends exactly 5_000 cycles later than unpaused.
- stop and start in the same cycle mid-note → next cycle busy=0, beep=0, done=0. start while busy → ignored (note_idx and counters unchanged).
- Entry 0xF2 plays 400_000 silent cycles. rst_n low mid-note → beep, busy, done, rom_addr go 0 immediately; playback does not resume after release without start.

Source files
------------

// File: rtl/melody_pkg.sv
// melody_pkg: shared definitions for the melody player.
//   pitch_e   - 4-bit pitch codes stored in song ROM entries
//   HP_TABLE  - tone half-periods in sys_clk cycles (48 MHz), 0 = silent
//   state_e   - playback FSM states
//   *_MSB/LSB - ROM entry field positions (pitch high nibble, beats low nibble)
package melody_pkg;

  typedef enum logic [3:0] {
    P_REST = 4'd0,
    P_L5   = 4'd1,
    P_L6   = 4'd2,
    P_M1   = 4'd3,
    P_M2   = 4'd4,
    P_M3   = 4'd5,
    P_M5   = 4'd6,
    P_M6   = 4'd7,
    P_H1   = 4'd8
  } pitch_e;

  // Codes 9..15 are reserved; a zero half-period makes them play as rest.
  localparam logic [15:0] HP_TABLE [16] = '{
    16'd0,     16'd61224, 16'd54545, 16'd45863,
    16'd40865, 16'd36402, 16'd30612, 16'd27273,
    16'd22956, 16'd0,     16'd0,     16'd0,
    16'd0,     16'd0,     16'd0,     16'd0
  };

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_PLAY,
    S_GAP
  } state_e;

  localparam int PITCH_MSB = 7;
  localparam int PITCH_LSB = 4;
  localparam int DUR_MSB   = 3;
  localparam int DUR_LSB   = 0;

  function automatic logic [15:0] hp_of(input pitch_e p);
    return HP_TABLE[p];
  endfunction

endpackage

// File: rtl/tone_gen.sv
// tone_gen: square-wave generator for the buzzer.
//   clk, rst_n - clock, async active-low reset
//   en         - run the half-period counter; when low beep is driven 0 and
//                the counter holds its value (pause / gap / rest)
//   clear      - restart: counter and beep to 0 (new note)
//   hp[15:0]   - half-period in cycles; 0 means silence
//   beep       - registered tone output, period 2*hp
module tone_gen (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        clear,
  input  logic [15:0] hp,
  output logic        beep
);

  logic [15:0] cnt_q, cnt_d;
  logic        beep_q, beep_d;

  always_comb begin
    cnt_d  = cnt_q;
    beep_d = beep_q;
    if (clear) begin
      cnt_d  = '0;
      beep_d = 1'b0;
    end else if (!en || hp == '0) begin
      beep_d = 1'b0;
    end else if (cnt_q == hp - 16'd1) begin
      cnt_d  = '0;
      beep_d = ~beep_q;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      beep_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      beep_q <= beep_d;
    end
  end

  assign beep = beep_q;

endmodule

// File: rtl/melody_player.sv
// melody_player: table-driven buzzer melody engine.
//   sys_clk, rst_n   - clock, async active-low reset
//   start, stop      - control pulses (stop wins); pause level freezes playback
//   loop_en          - restart from entry 0 at the end marker instead of finishing
//   rom_addr/rom_data- external synchronous song ROM ({pitch[7:4], beats[3:0]})
//   beep             - buzzer drive
//   busy, done       - playing / one-cycle normal completion pulse
//   note_idx         - ROM address of the note currently playing
module melody_player
  import melody_pkg::*;
#(
  parameter int CLK_HZ      = 48_000_000,
  parameter int BEAT_CYCLES = 12_000_000,
  parameter int GAP_CYCLES  = 480_000,
  parameter int ROM_AW      = 8
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              loop_en,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic              beep,
  output logic              busy,
  output logic              done,
  output logic [ROM_AW-1:0] note_idx
);

  // note_cnt must hold 15 beats; gap counter at least 1 bit even when disabled.
  localparam int NCW = $clog2(15 * BEAT_CYCLES + 1);
  localparam int GW  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

  if (GAP_CYCLES >= BEAT_CYCLES || GAP_CYCLES < 0 || CLK_HZ <= 0) begin : g_bad_param
    $error("melody_player: GAP_CYCLES must be in [0, BEAT_CYCLES) and CLK_HZ > 0");
  end

  state_e              state_q, state_d;
  logic [ROM_AW-1:0]   addr_q, addr_d, idx_q, idx_d;
  logic [NCW-1:0]      ncnt_q, ncnt_d;
  logic [GW-1:0]       gcnt_q, gcnt_d;
  logic [15:0]         hp_q, hp_d;
  logic                done_q, done_d, busy_q;
  logic                tone_en, tone_clr;
  logic [3:0]          dur;
  pitch_e              pitch;

  assign dur   = rom_data[DUR_MSB:DUR_LSB];
  assign pitch = pitch_e'(rom_data[PITCH_MSB:PITCH_LSB]);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    idx_d    = idx_q;
    ncnt_d   = ncnt_q;
    gcnt_d   = gcnt_q;
    hp_d     = hp_q;
    done_d   = 1'b0;
    tone_clr = 1'b0;
    if (stop) begin
      state_d = S_IDLE;
    end else if (pause && state_q != S_IDLE) begin
      // everything holds; tone_gen is stalled through tone_en below
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_FETCH;
            addr_d  = '0;
          end
        end
        S_FETCH: state_d = S_DECODE;
        S_DECODE: begin
          if (dur != 4'd0) begin
            hp_d     = hp_of(pitch);
            // PLAY covers the note minus its trailing articulation gap
            ncnt_d   = NCW'(dur) * NCW'(BEAT_CYCLES) - NCW'(GAP_CYCLES);
            idx_d    = addr_q;
            tone_clr = 1'b1;
            state_d  = S_PLAY;
          end else if (loop_en) begin
            addr_d  = '0;
            state_d = S_FETCH;
          end else begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_PLAY: begin
          if (ncnt_q == NCW'(1)) begin
            if (GAP_CYCLES == 0) begin
              addr_d  = addr_q + 1'b1;
              state_d = S_FETCH;
            end else begin
              gcnt_d  = GW'(GAP_CYCLES);
              state_d = S_GAP;
            end
          end else begin
            ncnt_d = ncnt_q - 1'b1;
          end
        end
        S_GAP: begin
          if (gcnt_q == GW'(1)) begin
            addr_d  = addr_q + 1'b1;
            state_d = S_FETCH;
          end else begin
            gcnt_d = gcnt_q - 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // The tone only runs while PLAY continues; the edge leaving PLAY (to GAP,
  // FETCH or IDLE) and every paused edge drive beep low.
  assign tone_en = (state_q == S_PLAY) && (state_d == S_PLAY) && !pause;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      idx_q   <= '0;
      ncnt_q  <= '0;
      gcnt_q  <= '0;
      hp_q    <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      ncnt_q  <= ncnt_d;
      gcnt_q  <= gcnt_d;
      hp_q    <= hp_d;
      done_q  <= done_d;
      busy_q  <= (state_d != S_IDLE);
    end
  end

  tone_gen u_tone (
    .clk   (sys_clk),
    .rst_n (rst_n),
    .en    (tone_en),
    .clear (tone_clr),
    .hp    (hp_q),
    .beep  (beep)
  );

  assign rom_addr = addr_q;
  assign note_idx = idx_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
